// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit
//  Description : Instruction fetch stage. Owns the PC, issues word-aligned
//                reads to instruction memory and buffers the returned words
//                in an in-order queue that feeds decode as IR/PC pairs.
//                A redirect reloads the PC, flushes the queue and kills any
//                responses still in flight.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] ir,
    output logic [31:0] ir_pc
);

    localparam int C_PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int C_CNT_W  = $clog2(DEPTH + 1);
    localparam int C_SUM_W  = C_CNT_W + 1;
    // Killed requests can pile up across several redirects while memory is
    // slow, so the drop counter is wider than the live in-flight counter.
    localparam int C_DROP_W = 8;
    localparam logic [C_PTR_W-1:0] C_LAST    = C_PTR_W'(DEPTH - 1);
    localparam logic [C_SUM_W-1:0] C_DEPTH_V = C_SUM_W'(DEPTH);

    // Architectural state
    logic [31:0]         pc_q, pc_d;
    logic                started_q, started_d;
    logic [C_CNT_W-1:0]  live_q, live_d;     // in-flight requests whose data is wanted
    logic [C_CNT_W-1:0]  cnt_q, cnt_d;       // instructions held in the queue
    logic [C_DROP_W-1:0] drop_q, drop_d;     // in-flight requests to be discarded

    // Instruction queue {word, pc}
    logic [31:0]         qw_q [DEPTH];
    logic [31:0]         qw_d [DEPTH];
    logic [31:0]         qp_q [DEPTH];
    logic [31:0]         qp_d [DEPTH];
    logic [C_PTR_W-1:0]  qh_q, qh_d, qt_q, qt_d;

    // Addresses of live in-flight requests, in issue order
    logic [31:0]         ap_q [DEPTH];
    logic [31:0]         ap_d [DEPTH];
    logic [C_PTR_W-1:0]  ah_q, ah_d, at_q, at_d;

    logic w_credit;
    logic w_fire;
    logic w_resp_live;
    logic w_resp_drop;
    logic w_push;
    logic w_pop;
    logic w_have;
    logic w_unused_redir_lo;

    function automatic logic [C_PTR_W-1:0] ptr_inc(input logic [C_PTR_W-1:0] p);
        return (p == C_LAST) ? '0 : p + 1'b1;
    endfunction

    // Only live requests consume credit; killed ones do not need a queue slot.
    assign w_credit    = ({1'b0, live_q} + {1'b0, cnt_q}) < C_DEPTH_V;
    assign w_have      = !rst && (cnt_q != '0);

    assign imem_req_valid = !rst && started_q && !redirect_valid && w_credit;
    assign imem_req_addr  = pc_q;
    assign ir_valid       = w_have && !redirect_valid;
    assign ir             = w_have ? qw_q[qh_q] : 32'h0;
    assign ir_pc          = w_have ? qp_q[qh_q] : 32'h0;

    // Responses are in order, so pending drops always belong to the oldest requests.
    assign w_fire      = imem_req_valid && imem_req_ready;
    assign w_resp_drop = imem_resp_valid && (drop_q != '0);
    assign w_resp_live = imem_resp_valid && (drop_q == '0);
    assign w_push      = w_resp_live && !redirect_valid;
    assign w_pop       = ir_valid && ir_ready;

    assign w_unused_redir_lo = ^redirect_pc[1:0];

    // Next-state computation for PC, counters, queue and address tracker
    always_comb begin
        pc_d      = pc_q;
        started_d = 1'b1;
        live_d    = live_q;
        cnt_d     = cnt_q;
        drop_d    = drop_q;
        qw_d      = qw_q;
        qp_d      = qp_q;
        qh_d      = qh_q;
        qt_d      = qt_q;
        ap_d      = ap_q;
        ah_d      = ah_q;
        at_d      = at_q;

        if (redirect_valid) begin
            // Everything still in flight after this cycle becomes a drop.
            pc_d   = {redirect_pc[31:2], 2'b00};
            live_d = '0;
            cnt_d  = '0;
            qh_d   = '0;
            qt_d   = '0;
            ah_d   = '0;
            at_d   = '0;
            drop_d = drop_q + C_DROP_W'(live_q) - C_DROP_W'(imem_resp_valid);
        end else begin
            if (w_fire) begin
                ap_d[at_q] = pc_q;
                at_d       = ptr_inc(at_q);
                pc_d       = pc_q + 32'd4;
            end
            if (w_resp_drop) begin
                drop_d = drop_q - C_DROP_W'(1);
            end
            if (w_resp_live) begin
                qw_d[qt_q] = imem_resp_data;
                qp_d[qt_q] = ap_q[ah_q];
                qt_d       = ptr_inc(qt_q);
                ah_d       = ptr_inc(ah_q);
            end
            if (w_pop) begin
                qh_d = ptr_inc(qh_q);
            end
            live_d = live_q + C_CNT_W'(w_fire) - C_CNT_W'(w_resp_live);
            cnt_d  = cnt_q + C_CNT_W'(w_push) - C_CNT_W'(w_pop);
        end
    end

    // State registers with synchronous reset taking priority over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            started_q <= 1'b0;
            live_q    <= '0;
            cnt_q     <= '0;
            drop_q    <= '0;
            qh_q      <= '0;
            qt_q      <= '0;
            ah_q      <= '0;
            at_q      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                qw_q[i] <= '0;
                qp_q[i] <= '0;
                ap_q[i] <= '0;
            end
        end else begin
            pc_q      <= pc_d;
            started_q <= started_d;
            live_q    <= live_d;
            cnt_q     <= cnt_d;
            drop_q    <= drop_d;
            qh_q      <= qh_d;
            qt_q      <= qt_d;
            ah_q      <= ah_d;
            at_q      <= at_d;
            qw_q      <= qw_d;
            qp_q      <= qp_d;
            ap_q      <= ap_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed bench for fetch_unit: cycle vector table plus
//                sequences for backpressure, redirects, PC wrap and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ir_valid, ir_ready;
    logic [31:0] ir, ir_pc;

    // Second instance for the PC wrap case
    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_ir_valid;
    logic [31:0] w_ir, w_ir_pc;
    logic        w_one = 1'b1;
    logic        w_zero = 1'b0;
    logic [31:0] w_zero32 = 32'h0;
    logic        wm_v;
    logic [31:0] wm_d;

    fetch_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
        .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
        .redirect_valid(redir), .redirect_pc(redir_pc),
        .ir_valid(ir_valid), .ir_ready(ir_ready), .ir(ir), .ir_pc(ir_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
        .clk(clk), .rst(rst),
        .imem_req_valid(w_req_valid), .imem_req_ready(w_one), .imem_req_addr(w_req_addr),
        .imem_resp_valid(wm_v), .imem_resp_data(wm_d),
        .redirect_valid(w_zero), .redirect_pc(w_zero32),
        .ir_valid(w_ir_valid), .ir_ready(w_one), .ir(w_ir), .ir_pc(w_ir_pc)
    );

    // Memory model: fixed latency, returns word = address
    int          lat;
    logic        mem_fire;
    logic [31:0] mem_addr;
    logic        pipe_v [8];
    logic [31:0] pipe_a [8];
    logic        wm_fire;
    logic [31:0] wm_addr;

    assign resp_valid = pipe_v[0];
    assign resp_data  = pipe_a[0];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                pipe_v[i] <= 1'b0;
                pipe_a[i] <= 32'h0;
            end
        end else begin
            for (int i = 0; i < 7; i++) begin
                pipe_v[i] <= pipe_v[i+1];
                pipe_a[i] <= pipe_a[i+1];
            end
            pipe_v[7] <= 1'b0;
            if (mem_fire) begin
                pipe_v[lat-1] <= 1'b1;
                pipe_a[lat-1] <= mem_addr;
            end
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            wm_v <= 1'b0;
            wm_d <= 32'h0;
        end else begin
            wm_v <= wm_fire;
            wm_d <= wm_addr;
        end
    end

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] pc;
    } out_t;

    out_t        out_q [$];
    logic [31:0] fire_q [$];
    logic [31:0] w_fire_q [$];

    typedef struct packed {
        logic        rst;
        logic        req_ready;
        logic        ir_ready;
        logic        redir;
        logic [31:0] redir_pc;
        logic        e_req_valid;
        logic [31:0] e_addr;
        logic        e_ir_valid;
        logic [31:0] e_ir;
        logic [31:0] e_ir_pc;
    } vec_t;

    vec_t vecs [12];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic apply(input logic r, input logic rr, input logic irr,
                         input logic rv, input logic [31:0] rp);
        rst      = r;
        req_ready = rr;
        ir_ready = irr;
        redir    = rv;
        redir_pc = rp;
        #1;
    endtask

    // Log this cycle's handshakes, latch memory requests, move to next cycle
    task automatic finish_cycle();
        mem_fire = req_valid && req_ready;
        mem_addr = req_addr;
        wm_fire  = w_req_valid;
        wm_addr  = w_req_addr;
        if (!rst) begin
            if (mem_fire) fire_q.push_back(req_addr);
            if (ir_valid && ir_ready) out_q.push_back(out_t'({ir, ir_pc}));
            if (w_req_valid) w_fire_q.push_back(w_req_addr);
        end
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic irr);
        for (int i = 0; i < n; i++) begin
            apply(1'b0, 1'b1, irr, 1'b0, 32'h0);
            finish_cycle();
        end
    endtask

    task automatic do_reset(input int l);
        lat = l;
        for (int i = 0; i < 2; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
            finish_cycle();
        end
        out_q.delete();
        fire_q.delete();
        w_fire_q.delete();
    endtask

    task automatic chk_out(input string name, input int idx, input logic [31:0] exp);
        if (idx < out_q.size()) begin
            chk({name, " ir_pc"}, out_q[idx].pc, exp);
            chk({name, " ir"}, out_q[idx].w, exp);
        end else begin
            chk({name, " delivered"}, 32'(out_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_fire(input string name, input int idx, input logic [31:0] exp);
        if (idx < fire_q.size()) chk(name, fire_q[idx], exp);
        else chk({name, " issued"}, 32'(fire_q.size()), 32'(idx + 1));
    endtask

    // Count delivered pairs older than a boundary or with word != pc
    task automatic chk_no_stale(input string name, input logic [31:0] lo);
        int stale = 0;
        foreach (out_q[i]) if (out_q[i].pc < lo || out_q[i].w != out_q[i].pc) stale++;
        chk(name, 32'(stale), 32'h0);
    endtask

    initial begin
        rst = 1'b1; req_ready = 1'b1; ir_ready = 1'b1; redir = 1'b0; redir_pc = 32'h0;
        mem_fire = 1'b0; mem_addr = 32'h0; wm_fire = 1'b0; wm_addr = 32'h0; lat = 1;

        //          rst   rrdy  irdy  redir redir_pc      rv    addr          iv    ir            ir_pc
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0000_0100, 1'b0, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0000_0100, 1'b0, 32'h0,        32'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_0100, 1'b0, 32'h0,        32'h0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_0104, 1'b0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0000_0108, 1'b1, 32'h0000_0100, 32'h0000_0100};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_0108, 1'b1, 32'h0000_0104, 32'h0000_0104};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_010C, 1'b0, 32'h0,        32'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h3001,   1'b0, 32'h0000_0110, 1'b0, 32'h0000_0108, 32'h0000_0108};
        vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_3000, 1'b0, 32'h0,        32'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_3004, 1'b0, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b0, 32'h0000_3008, 1'b1, 32'h0000_3000, 32'h0000_3000};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,      1'b1, 32'h0000_3008, 1'b1, 32'h0000_3004, 32'h0000_3004};

        @(negedge clk);

        // Reset, streaming start-up and redirect coinciding with response + pop
        do_reset(1);
        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].rst, vecs[i].req_ready, vecs[i].ir_ready, vecs[i].redir, vecs[i].redir_pc);
            chk($sformatf("vec%0d req_valid", i), 32'(req_valid), 32'(vecs[i].e_req_valid));
            chk($sformatf("vec%0d req_addr", i), req_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d ir_valid", i), 32'(ir_valid), 32'(vecs[i].e_ir_valid));
            chk($sformatf("vec%0d ir", i), ir, vecs[i].e_ir);
            chk($sformatf("vec%0d ir_pc", i), ir_pc, vecs[i].e_ir_pc);
            finish_cycle();
        end
        chk_no_stale("vec stream order", 32'h0);

        // PC wrap on the second instance, run alongside the table above
        if (w_fire_q.size() >= 3) begin
            chk("wrap addr0", w_fire_q[0], 32'hFFFF_FFF8);
            chk("wrap addr1", w_fire_q[1], 32'hFFFF_FFFC);
            chk("wrap addr2", w_fire_q[2], 32'h0000_0000);
        end else begin
            chk("wrap issued", 32'(w_fire_q.size()), 32'd3);
        end

        // Backpressure: only DEPTH requests issue while decode stalls
        do_reset(1);
        run(10, 1'b0);
        chk("bp issued", 32'(fire_q.size()), 32'd2);
        chk_fire("bp fire0", 0, 32'h100);
        chk_fire("bp fire1", 1, 32'h104);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("bp req_valid", 32'(req_valid), 32'd0);
        chk("bp ir_valid", 32'(ir_valid), 32'd1);
        chk("bp ir head", ir, 32'h100);
        finish_cycle();
        run(8, 1'b1);
        chk_out("bp out0", 0, 32'h100);
        chk_out("bp out1", 1, 32'h104);
        chk_out("bp out2", 2, 32'h108);
        chk_fire("bp fire2", 2, 32'h108);

        // Redirect with two requests in flight, memory latency 3
        do_reset(3);
        run(3, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h2003);
        chk("redir req_valid", 32'(req_valid), 32'd0);
        finish_cycle();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("redir next req_valid", 32'(req_valid), 32'd1);
        chk("redir next addr", req_addr, 32'h2000);
        finish_cycle();
        run(15, 1'b1);
        chk_out("redir out0", 0, 32'h2000);
        chk_out("redir out1", 1, 32'h2004);
        chk_no_stale("redir stale", 32'h2000);

        // Back-to-back redirects: last target wins, all old responses dropped
        do_reset(3);
        run(3, 1'b1);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h2000);
        finish_cycle();
        apply(1'b0, 1'b1, 1'b1, 1'b1, 32'h4000);
        chk("b2b req_valid", 32'(req_valid), 32'd0);
        finish_cycle();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("b2b next addr", req_addr, 32'h4000);
        finish_cycle();
        run(15, 1'b1);
        chk_fire("b2b fire2", 2, 32'h4000);
        chk_out("b2b out0", 0, 32'h4000);
        chk_out("b2b out1", 1, 32'h4004);
        chk_no_stale("b2b stale", 32'h4000);

        // Reset in the middle of a stream with a full queue
        do_reset(1);
        run(6, 1'b0);
        apply(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("mid full ir_valid", 32'(ir_valid), 32'd1);
        finish_cycle();
        apply(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mid rst ir_valid", 32'(ir_valid), 32'd0);
        chk("mid rst req_valid", 32'(req_valid), 32'd0);
        chk("mid rst ir", ir, 32'h0);
        finish_cycle();
        out_q.delete();
        fire_q.delete();
        apply(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("mid after ir_valid", 32'(ir_valid), 32'd0);
        chk("mid after req_valid", 32'(req_valid), 32'd0);
        chk("mid after addr", req_addr, 32'h100);
        chk("mid after ir_pc", ir_pc, 32'h0);
        finish_cycle();
        run(10, 1'b1);
        chk_fire("mid fire0", 0, 32'h100);
        chk_out("mid out0", 0, 32'h100);
        chk_out("mid out1", 1, 32'h104);
        chk_no_stale("mid stale", 32'h100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
